modexp_ctrl: RTL and testbench

//  Square-and-multiply sequencer for RSA modular exponentiation: result = base^exponent mod modulus.

---
 rtl/rsa_pkg.sv | 26 ++
 rtl/modexp_ctrl.sv | 165 ++++++++++++++++
 tb/tb_modexp_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared widths, FSM states and reduction op codes for the modexp sequencer
//   DEF_DATA_W : default width of base, modulus and result
//   DEF_EXP_W  : default exponent width
//   state_t    : sequencer states
//   op_t       : which register a reduced value is folded back into
package rsa_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_EXP_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RCLR,
        S_RRUN,
        S_UPDATE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_BASE,
        OP_MUL,
        OP_SQR
    } op_t;

endpackage

// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - square-and-multiply sequencer driving an external repeated-subtraction reducer
//   clock_i, reset_i         : clock, asynchronous active-high reset
//   start_i                  : one-cycle request, accepted in IDLE/DONE
//   base_i, exponent_i,
//   modulus_i                : operands latched on an accepted start
//   result_o, ready_o,
//   busy_o, error_o          : result (valid while ready_o), status
//   red_x_o, red_y_o         : operand and modulus handed to the reducer
//   red_reset_o, red_enable_o: reducer clear pulse and run request
//   red_result_i, red_ready_i: reducer output and done level
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   base_i,
    input  logic [EXP_W-1:0]    exponent_i,
    input  logic [DATA_W-1:0]   modulus_i,
    output logic [DATA_W-1:0]   result_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic                error_o,
    output logic [2*DATA_W-1:0] red_x_o,
    output logic [DATA_W-1:0]   red_y_o,
    output logic                red_reset_o,
    output logic                red_enable_o,
    input  logic [DATA_W-1:0]   red_result_i,
    input  logic                red_ready_i
);

    state_t              state_q;
    op_t                 op_q;
    logic [DATA_W-1:0]   m_q, n_q, acc_q, b_q;
    logic [EXP_W-1:0]    e_q;
    logic [DATA_W-1:0]   result_q, red_y_q;
    logic [2*DATA_W-1:0] red_x_q;
    logic                ready_q, busy_q, error_q, red_reset_q, red_enable_q;

    // Register values after folding in the current reduction; the next
    // product is formed from these so it can be issued straight from UPDATE.
    logic [DATA_W-1:0]   acc_d, b_d;
    logic [EXP_W-1:0]    e_d;
    logic [2*DATA_W-1:0] prod_ab, prod_bb;

    always_comb begin
        acc_d   = (op_q == OP_MUL) ? red_result_i : acc_q;
        b_d     = (op_q == OP_MUL) ? b_q : red_result_i;
        e_d     = (op_q == OP_SQR) ? (e_q >> 1) : e_q;
        prod_ab = {{DATA_W{1'b0}}, acc_d} * {{DATA_W{1'b0}}, b_d};
        prod_bb = {{DATA_W{1'b0}}, b_d} * {{DATA_W{1'b0}}, b_d};
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            op_q         <= OP_BASE;
            m_q          <= '0;
            n_q          <= '0;
            e_q          <= '0;
            acc_q        <= '0;
            b_q          <= '0;
            result_q     <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            red_x_q      <= '0;
            red_y_q      <= '0;
            // Held high so the reducer is cleared for as long as reset lasts.
            red_reset_q  <= 1'b1;
            red_enable_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    red_reset_q  <= 1'b0;
                    red_enable_q <= 1'b0;
                    if (start_i) begin
                        m_q     <= base_i;
                        e_q     <= exponent_i;
                        n_q     <= modulus_i;
                        red_y_q <= modulus_i;
                        ready_q <= 1'b0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (n_q == '0 || n_q == DATA_W'(1)) begin
                        error_q  <= (n_q == '0);
                        result_q <= '0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        acc_q       <= DATA_W'(1);
                        op_q        <= OP_BASE;
                        red_x_q     <= {{DATA_W{1'b0}}, m_q};
                        red_reset_q <= 1'b1;
                        state_q     <= S_RCLR;
                    end
                end
                S_RCLR: begin
                    red_reset_q  <= 1'b0;
                    red_enable_q <= 1'b1;
                    state_q      <= S_RRUN;
                end
                S_RRUN: begin
                    // red_ready_i is only trusted here, after the RCLR pulse
                    // has wiped any stale done level from the previous run.
                    if (red_ready_i) begin
                        red_enable_q <= 1'b0;
                        state_q      <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    acc_q <= acc_d;
                    b_q   <= b_d;
                    e_q   <= e_d;
                    if (op_q == OP_MUL) begin
                        if ((e_q >> 1) != '0) begin
                            op_q        <= OP_SQR;
                            red_x_q     <= prod_bb;
                            red_reset_q <= 1'b1;
                            state_q     <= S_RCLR;
                        end else begin
                            // Last exponent bit consumed: the trailing square
                            // would be unused, so finish on the multiply.
                            result_q <= red_result_i;
                            ready_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end
                    end else if (e_d == '0) begin
                        result_q <= acc_d;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        op_q        <= e_d[0] ? OP_MUL : OP_SQR;
                        red_x_q     <= e_d[0] ? prod_ab : prod_bb;
                        red_reset_q <= 1'b1;
                        state_q     <= S_RCLR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign result_o     = result_q;
    assign ready_o      = ready_q;
    assign busy_o       = busy_q;
    assign error_o      = error_q;
    assign red_x_o      = red_x_q;
    assign red_y_o      = red_y_q;
    assign red_reset_o  = red_reset_q;
    assign red_enable_o = red_enable_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - directed scoreboard bench for modexp_ctrl with a behavioural reducer
module tb_modexp_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base, exponent, modulus;
    logic [7:0]  result;
    logic        ready, busy, error;
    logic [15:0] red_x;
    logic [7:0]  red_y;
    logic        red_reset, red_enable;
    logic [7:0]  red_result;
    logic        red_ready;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    modexp_ctrl dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .start_i      (start),
        .base_i       (base),
        .exponent_i   (exponent),
        .modulus_i    (modulus),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy),
        .error_o      (error),
        .red_x_o      (red_x),
        .red_y_o      (red_y),
        .red_reset_o  (red_reset),
        .red_enable_o (red_enable),
        .red_result_i (red_result),
        .red_ready_i  (red_ready)
    );

    // Repeated-subtraction reducer: capture x on the first enabled cycle,
    // subtract y once per cycle, then hold the done level until cleared.
    logic [15:0] rx;
    logic        rrun;
    always @(posedge clock) begin
        if (red_reset) begin
            rrun      <= 1'b0;
            red_ready <= 1'b0;
        end else if (red_enable && !red_ready) begin
            if (!rrun) begin
                rrun <= 1'b1;
                rx   <= red_x;
            end else if (rx >= {8'd0, red_y}) begin
                rx <= rx - {8'd0, red_y};
            end else begin
                red_ready  <= 1'b1;
                red_result <= rx[7:0];
            end
        end
    end

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         nred;
        int         en0;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int b, input int e, input int n);
        exp_t x;
        int   pc, bl;
        x.err = (n == 0);
        x.en0 = 0;
        if (n <= 1) begin
            x.res  = 8'd0;
            x.nred = 0;
        end else begin
            int r = 1;
            for (int i = 0; i < e; i++) r = (r * b) % n;
            x.res = r[7:0];
            pc = 0;
            bl = 0;
            for (int i = 0; i < 8; i++) begin
                if ((e >> i) & 1) begin
                    pc++;
                    bl = i + 1;
                end
            end
            x.nred = (e == 0) ? 1 : 1 + pc + bl - 1;
        end
        return x;
    endfunction

    int   done_cnt = 0;
    int   en_rises = 0;
    logic prev_rdy = 1'b0;
    logic prev_en  = 1'b0;

    always @(posedge clock) begin
        exp_t x;
        #1;
        if (red_enable && !prev_en) en_rises++;
        if (ready && !prev_rdy) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_ready", 1, 0);
            end else begin
                x = sb.pop_front();
                chk("result", {24'd0, result}, {24'd0, x.res});
                chk("error", {31'd0, error}, {31'd0, x.err});
                chk("reductions", en_rises - x.en0, x.nred);
                chk("busy_at_done", {31'd0, busy}, 0);
            end
        end
        prev_rdy = ready;
        prev_en  = red_enable;
    end

    task automatic pulse_start(input int b, input int e, input int n);
        @(negedge clock);
        start    = 1'b1;
        base     = b[7:0];
        exponent = e[7:0];
        modulus  = n[7:0];
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 5000 && done_cnt == d0; i++) @(negedge clock);
        if (done_cnt == d0) chk("timeout", done_cnt, d0 + 1);
    endtask

    task automatic run_op(input int b, input int e, input int n);
        exp_t x;
        int   d0;
        x     = model(b, e, n);
        x.en0 = en_rises;
        sb.push_back(x);
        d0 = done_cnt;
        pulse_start(b, e, n);
        wait_done(d0);
    endtask

    initial begin
        int d0;
        int k;
        reset    = 1'b1;
        start    = 1'b0;
        base     = 8'd0;
        exponent = 8'd0;
        modulus  = 8'd0;
        repeat (3) @(negedge clock);
        chk("rst_ready", {31'd0, ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_red_reset", {31'd0, red_reset}, 1);
        chk("rst_red_enable", {31'd0, red_enable}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Spec-given vectors; the model yields the same constants.
        chk("model_3_5_7", {24'd0, model(3, 5, 7).res}, 5);
        run_op(3, 5, 7);
        chk("ready_held", {31'd0, ready}, 1);
        run_op(2, 7, 33);
        run_op(29, 3, 33);
        run_op(200, 2, 13);
        run_op(5, 0, 7);
        run_op(9, 200, 1);
        run_op(7, 3, 0);
        run_op(1, 255, 251);
        run_op(250, 129, 251);

        // Reset while a reduction is running aborts with nothing kept.
        pulse_start(2, 7, 33);
        k = 0;
        while (!red_enable && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("reached_rrun", {31'd0, red_enable}, 1);
        d0    = done_cnt;
        reset = 1'b1;
        #1;
        chk("abort_result", {24'd0, result}, 0);
        chk("abort_ready", {31'd0, ready}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_error", {31'd0, error}, 0);
        chk("abort_red_x", {16'd0, red_x}, 0);
        chk("abort_red_y", {24'd0, red_y}, 0);
        chk("abort_red_enable", {31'd0, red_enable}, 0);
        chk("abort_red_reset", {31'd0, red_reset}, 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("abort_no_done", done_cnt, d0);
        run_op(2, 7, 33);

        // A second start while busy must be dropped.
        begin
            exp_t x;
            x     = model(3, 5, 7);
            x.en0 = en_rises;
            sb.push_back(x);
            d0 = done_cnt;
            pulse_start(3, 5, 7);
            repeat (3) @(negedge clock);
            chk("busy_mid", {31'd0, busy}, 1);
            pulse_start(4, 3, 11);
            wait_done(d0);
            repeat (30) @(negedge clock);
            chk("single_ready", done_cnt, d0 + 1);
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
